// File: rtl/npu_pkg.sv
// Shared NPU input-path constants and the pixel loader state encoding.
package npu_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int PIX_W      = 8;
  localparam int PIX_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pixel_loader_if.sv
// Valid/ready pixel byte stream with a start-of-frame qualifier.
interface pixel_loader_if #(
  parameter int BIT_DEPTH = 8
);

  logic                 s_valid;
  logic                 s_ready;
  logic [BIT_DEPTH-1:0] s_data;
  logic                 s_sof;

  modport master (
    output s_valid,
    output s_data,
    output s_sof,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_sof,
    output s_ready
  );

endinterface

// File: rtl/pixel_loader.sv
// Writes one frame of streamed pixels to sequential LUTRAM addresses; write port is 1 cycle after accept.
// s_ready is registered from state alone and drops while a full frame awaits frame_ack.
module pixel_loader
  import npu_pkg::*;
#(
  parameter int BIT_DEPTH  = PIX_W,
  parameter int ADDR_WIDTH = PIX_ADDR_W,
  parameter int DEPTH      = IMG_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_loader_if.slave         s_if,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [BIT_DEPTH-1:0]  data_in,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic                  sync_err,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] pix_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  loader_state_t         r_state;
  logic                  r_s_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [BIT_DEPTH-1:0]  r_data_in;
  logic                  r_frame_valid;
  logic                  r_sync_err;
  logic [ADDR_WIDTH-1:0] r_pix_count;

  logic w_fire;
  logic w_err;

  assign w_fire = s_if.s_valid & r_s_ready;
  // Framing errors: a non-sof beat opening a frame, or a sof beat arriving mid-frame.
  assign w_err  = w_fire & (((r_state == IDLE) & ~s_if.s_sof) |
                            ((r_state == LOAD) &  s_if.s_sof));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_s_ready     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_data_in     <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_pix_count   <= '0;
    end else begin
      r_wr_en <= 1'b0;

      if (w_err) begin
        r_sync_err <= 1'b1;
      end else if (err_clr) begin
        r_sync_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_fire && s_if.s_sof) begin
            r_wr_en     <= 1'b1;
            r_wr_addr   <= '0;
            r_data_in   <= s_if.s_data;
            r_pix_count <= ADDR_WIDTH'(1);
            r_state     <= LOAD;
          end
        end

        LOAD: begin
          if (w_fire) begin
            r_wr_en   <= 1'b1;
            r_data_in <= s_if.s_data;
            if (s_if.s_sof) begin
              r_wr_addr   <= '0;
              r_pix_count <= ADDR_WIDTH'(1);
            end else begin
              r_wr_addr   <= r_pix_count;
              r_pix_count <= r_pix_count + ADDR_WIDTH'(1);
              if (r_pix_count == LAST_ADDR) begin
                r_state       <= FULL;
                r_s_ready     <= 1'b0;
                r_frame_valid <= 1'b1;
              end
            end
          end
        end

        FULL: begin
          if (frame_ack) begin
            r_state       <= IDLE;
            r_s_ready     <= 1'b1;
            r_frame_valid <= 1'b0;
            r_pix_count   <= '0;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.s_ready = r_s_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign data_in      = r_data_in;
  assign frame_valid  = r_frame_valid;
  assign sync_err     = r_sync_err;
  assign pix_count    = r_pix_count;

endmodule

// File: doc/pixel_loader.md
Name: pixel_loader

Overview:
- Upstream write stage for the 8x784 image LUTRAM in the NPU input path.
- Accepts a valid/ready pixel byte stream and drives the LUTRAM write port at sequential addresses 0..DEPTH-1.
- Reports frame completion and holds off new input until the downstream compute stage acknowledges consumption.
- Flags framing errors using the stream's start-of-frame marker.

Parameters:
- BIT_DEPTH, 8: pixel width; matches the LUTRAM data width.
- ADDR_WIDTH, 10: LUTRAM address width.
- DEPTH, 784: pixels per frame (28x28).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  loader can accept a pixel.
- s_data  input  BIT_DEPTH  pixel value.
- s_sof  input  1  qualifies the current beat as the first pixel of a frame.
- wr_en  output  1  LUTRAM write enable.
- wr_addr  output  ADDR_WIDTH  LUTRAM write address.
- data_in  output  BIT_DEPTH  LUTRAM write data.
- frame_valid  output  1  a full frame is resident in the LUTRAM.
- frame_ack  input  1  downstream has finished reading the frame; one-cycle pulse.
- sync_err  output  1  sticky framing error flag.
- err_clr  input  1  clears sync_err.
- pix_count  output  ADDR_WIDTH  pixels written in the current frame.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, s_ready=0, wr_en=0, wr_addr=0, data_in=0, frame_valid=0, sync_err=0, pix_count=0. Reset mid-frame discards the partial frame.
- Handshake: a beat transfers when s_valid & s_ready on a rising edge. s_ready is a registered output and depends only on state.
- States:
  - IDLE: s_ready=1. A beat with s_sof=1 is written to address 0 and moves to LOAD with pix_count=1. A beat with s_sof=0 is dropped (no write) and sets sync_err.
  - LOAD: s_ready=1. Each accepted beat is written to address pix_count and pix_count increments. When the beat written to address DEPTH-1 is accepted, go to FULL.
  - LOAD resync: a beat with s_sof=1 restarts the frame. It is written to address 0, pix_count=1, sync_err is set, and the state stays LOAD.
  - FULL: frame_valid=1, s_ready=0. On frame_ack go to IDLE: frame_valid=0, pix_count=0, and s_ready=1 from the next cycle.
  - FULL, frame_ack outside FULL: ignored.
- Write timing: wr_en, wr_addr and data_in are registered. They assert in the cycle after the accepting edge, for exactly one cycle per accepted beat. The LUTRAM captures the write on the following edge, so the total latency from accepting edge to data written is 2 clocks.
- Transition to FULL: the state enters FULL and frame_valid rises on the edge after the last beat is accepted. wr_en for pixel DEPTH-1 asserts in that same cycle. The downstream stage must not sample address DEPTH-1 before frame_valid has been high for one cycle.
- Boundaries:
  - The last pixel at DEPTH-1 never wraps to 0 inside a frame; the counter stops and the state moves to FULL.
  - pix_count never exceeds DEPTH.
  - Back-to-back beats are supported at one pixel per clock.
- Error flag:
  - sync_err is sticky and clears on err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins (sync_err stays 1).
- Arithmetic: the counter is ADDR_WIDTH bits unsigned, with a terminal compare against DEPTH-1. Pixel data passes through unmodified.

Decomposition:
- Shared package npu_pkg holds:
  - constants IMG_W=28, IMG_H=28, IMG_PIXELS=784, PIX_W=8, PIX_ADDR_W=10;
  - a typedef for the loader state enum (IDLE, LOAD, FULL).
- No sub-module. Counter, FSM and output registers fit in one module; the LUTRAM is instantiated alongside it at the parent level.

Test Plan:
1. Reset then a full frame: 784 beats, first with s_sof=1, data = addr mod 256, s_valid held high.
   - Required: each LUTRAM address reads back addr mod 256.
   - Required: frame_valid rises 1 clock after the 784th beat is accepted; s_ready=0 afterwards; sync_err=0.
2. Backpressure: further s_valid beats while in FULL.
   - Required: no wr_en.
   - Required: frame_ack pulse returns the loader to IDLE with pix_count=0; the next sof frame loads correctly.
3. Missing sof: beat 0x55 with s_sof=0 in IDLE.
   - Required: no write, sync_err=1.
   - Required: err_clr clears sync_err; err_clr in the same cycle as a new error leaves sync_err=1.
4. Mid-frame resync: after 300 beats, a beat 0xAA with s_sof=1.
   - Required: address 0 holds 0xAA, pix_count=1, sync_err=1.
   - Required: frame_valid only after a further 783 beats.
5. Reset mid-frame: rst_n low after 500 beats.
   - Required: all outputs at reset values immediately (asynchronous), state=IDLE, no wr_en until a new sof beat.
6. Random s_valid gaps (~50% duty) over a full frame.
   - Required: exactly 784 wr_en pulses, strictly increasing addresses 0..783, data order preserved.
